apb_sync_bridge: RTL
====================

Name: apb_sync_bridge

Overview:
- Single-clock APB4 register slice. It breaks the timing path between an APB master segment and an APB slave segment.
- Generalises the existing bridge transport:
  - parametrised address and data widths
  - PSTRB/PPROT pass-through
  - registered request and response paths
  - optional downstream timeout with error response
- Sits between the interconnect and peripheral clusters that share one clock.

Parameters:
- APB_ADDR_WIDTH, 32, address width.
- APB_DATA_WIDTH, 32, data width; must be a multiple of 8. Strobe width is APB_DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, number of ACCESS cycles without m_PREADY_i before the transfer is aborted. Range 2..65535. Used only with the timeout feature.

Ports:
- clk  in  1  bridge clock
- rst_n  in  1  asynchronous active-low reset
- PADDR_i  in  APB_ADDR_WIDTH  upstream address
- PWDATA_i  in  APB_DATA_WIDTH  upstream write data
- PWRITE_i  in  1  upstream direction
- PSTRB_i  in  APB_DATA_WIDTH/8  upstream write strobes
- PPROT_i  in  3  upstream protection
- PSEL_i  in  1  upstream select
- PENABLE_i  in  1  upstream enable
- PRDATA_o  out  APB_DATA_WIDTH  upstream read data
- PREADY_o  out  1  upstream ready
- PSLVERR_o  out  1  upstream error
- m_PADDR_o  out  APB_ADDR_WIDTH  downstream address
- m_PWDATA_o  out  APB_DATA_WIDTH  downstream write data
- m_PWRITE_o  out  1  downstream direction
- m_PSTRB_o  out  APB_DATA_WIDTH/8  downstream strobes
- m_PPROT_o  out  3  downstream protection
- m_PSEL_o  out  1  downstream select
- m_PENABLE_o  out  1  downstream enable
- m_PRDATA_i  in  APB_DATA_WIDTH  downstream read data
- m_PREADY_i  in  1  downstream ready
- m_PSLVERR_i  in  1  downstream error
- timeout_o  out  1  one-cycle pulse when a transfer is aborted by timeout

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs are 0. FSM is in IDLE. Timeout counter is 0.
- All outputs are registered; there is no combinational path from any input to any output.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On PSEL_i=1 and PREADY_o=0, capture PADDR/PWDATA/PWRITE/PSTRB/PPROT, then go to SETUP.
  - PSTRB is captured as 0 when PWRITE_i=0, per the APB4 read rule.
- SETUP: m_PSEL_o=1, m_PENABLE_o=0 for exactly one cycle, then ACCESS.
- ACCESS:
  - m_PSEL_o=1, m_PENABLE_o=1.
  - On m_PREADY_i=1: capture m_PRDATA_i, or 0 for a write; capture m_PSLVERR_i; drop m_PSEL_o and m_PENABLE_o on the next edge; go to RESP.
- RESP:
  - PREADY_o=1 for exactly one cycle with the captured PRDATA_o/PSLVERR_o, then IDLE.
  - Outside RESP, PRDATA_o=0, PSLVERR_o=0 and PREADY_o=0.
- Latency:
  - With a zero-wait downstream slave, upstream PREADY_o rises 3 cycles after the upstream setup cycle.
  - Each downstream wait state adds one cycle.
- Request hold: m_PADDR_o and the other request fields hold their captured value from SETUP until the next capture. They are not cleared on completion.
- Back-to-back transfers:
  - A new upstream setup is accepted in IDLE only.
  - The minimum gap is one IDLE cycle between RESP and the next SETUP.
- Upstream protocol violation: if PSEL_i drops while in SETUP or ACCESS, the downstream transfer still completes. The response is discarded: RESP is skipped and the FSM goes from ACCESS straight to IDLE with PREADY_o kept 0.
- m_PREADY_i is ignored outside ACCESS.
- Reset mid-transfer: all state clears immediately, and m_PSEL_o/m_PENABLE_o drop asynchronously.

Optional Feature:
- Macro: APB_SYNC_BRIDGE_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to ACCESS and increments each ACCESS cycle with m_PREADY_i=0.
  - When the count reaches TIMEOUT_CYCLES-1 and m_PREADY_i=0, the downstream select and enable drop on the next edge and the FSM goes to RESP with PSLVERR_o=1 and PRDATA_o=0. timeout_o pulses high for 1 cycle, coincident with the RESP entry edge.
  - m_PREADY_i=1 on the terminal-count cycle wins: the transfer completes normally and there is no timeout.
- Undefined: ACCESS waits indefinitely, timeout_o is tied to 0, and no counter is synthesised.

Decomposition:
- Shared package apb_bridge_pkg:
  - FSM state enum: IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3.
  - APB_PROT_WIDTH=3.
  - Strobe-width function (data width / 8).
- One sub-module, apb_bridge_timeout_cnt:
  - Parametrised by TIMEOUT_CYCLES.
  - Inputs: clear, count enable.
  - Output: expire.
  - Instantiated only under the macro.

Test Plan:
- Write, zero-wait slave: PADDR=0x0000_1004, PWDATA=0xDEAD_BEEF, PSTRB=4'b0110, PPROT=3'b010 -> m_* fields match exactly; m_PSEL for 2 cycles; PREADY_o high 3 cycles after setup; PSLVERR_o=0.
- Read, 5 wait states, m_PRDATA=0x1234_5678 -> m_PSTRB_o=0; PRDATA_o=0x1234_5678 only in the single PREADY_o cycle; total latency 8 cycles.
- Downstream error: read with m_PSLVERR_i=1 at ready -> PSLVERR_o=1 with PREADY_o; next transfer returns PSLVERR_o=0.
- Timeout with macro, TIMEOUT_CYCLES=4, m_PREADY_i stuck 0 -> m_PENABLE_o high 4 cycles then low; timeout_o one pulse; PSLVERR_o=1, PRDATA_o=0. Ready on cycle 4 -> normal completion, no pulse.
- Abort and reset: PSEL_i dropped during ACCESS -> downstream completes, no PREADY_o pulse, FSM returns to IDLE. rst_n asserted mid-ACCESS -> all outputs 0 immediately; next transfer works.
- Back-to-back: 4 consecutive writes to 0x0, 0x4, 0x8, 0xC -> each forwarded in order with one IDLE gap; no field corruption.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared types and helpers for the APB synchronous register-slice bridge.
package apb_bridge_pkg;

    localparam int unsigned APB_PROT_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    function automatic int unsigned strb_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/apb_bridge_timeout_cnt.sv
// ACCESS-phase wait counter for the APB bridge; expire flags the terminal count.
module apb_bridge_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TERMINAL = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Saturate at the terminal count; the bridge leaves ACCESS on expiry anyway.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != TERMINAL)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // expire is registered alongside the count so it always equals (cnt_q == TERMINAL).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            expire <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            expire <= (cnt_d == TERMINAL);
        end
    end

endmodule

// File: rtl/apb_sync_bridge.sv
// Single-clock APB4 register slice with fully registered request/response paths.
// Optional downstream timeout enabled by defining APB_SYNC_BRIDGE_TIMEOUT_EN.
module apb_sync_bridge
    import apb_bridge_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [APB_ADDR_WIDTH-1:0]     PADDR_i,
    input  logic [APB_DATA_WIDTH-1:0]     PWDATA_i,
    input  logic                          PWRITE_i,
    input  logic [APB_DATA_WIDTH/8-1:0]   PSTRB_i,
    input  logic [2:0]                    PPROT_i,
    input  logic                          PSEL_i,
    input  logic                          PENABLE_i,
    output logic [APB_DATA_WIDTH-1:0]     PRDATA_o,
    output logic                          PREADY_o,
    output logic                          PSLVERR_o,
    output logic [APB_ADDR_WIDTH-1:0]     m_PADDR_o,
    output logic [APB_DATA_WIDTH-1:0]     m_PWDATA_o,
    output logic                          m_PWRITE_o,
    output logic [APB_DATA_WIDTH/8-1:0]   m_PSTRB_o,
    output logic [2:0]                    m_PPROT_o,
    output logic                          m_PSEL_o,
    output logic                          m_PENABLE_o,
    input  logic [APB_DATA_WIDTH-1:0]     m_PRDATA_i,
    input  logic                          m_PREADY_i,
    input  logic                          m_PSLVERR_i,
    output logic                          timeout_o
);

    localparam int unsigned AW = APB_ADDR_WIDTH;
    localparam int unsigned DW = APB_DATA_WIDTH;
    localparam int unsigned SW = strb_width(APB_DATA_WIDTH);
    localparam int unsigned PW = APB_PROT_WIDTH;

    // Elaboration-time parameter sanity checks.
    if ((DW == 0) || ((DW % 8) != 0)) begin : g_bad_data_width
        $error("apb_sync_bridge: APB_DATA_WIDTH must be a non-zero multiple of 8");
    end
    if ((TIMEOUT_CYCLES < 2) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
        $error("apb_sync_bridge: TIMEOUT_CYCLES must be in 2..65535");
    end

    // Acceptance keys on PSEL_i in IDLE only; PENABLE_i carries nothing extra.
    logic unused_penable;
    assign unused_penable = PENABLE_i;

    apb_state_e state_q, state_d;
    logic       aborted_q, aborted_d;

    logic [AW-1:0] paddr_q, paddr_d;
    logic [DW-1:0] pwdata_q, pwdata_d;
    logic          pwrite_q, pwrite_d;
    logic [SW-1:0] pstrb_q, pstrb_d;
    logic [PW-1:0] pprot_q, pprot_d;

    logic          m_psel_q, m_psel_d;
    logic          m_penable_q, m_penable_d;
    logic          pready_q, pready_d;
    logic [DW-1:0] prdata_q, prdata_d;
    logic          pslverr_q, pslverr_d;
    logic          abort_now;
    logic          expire;

`ifdef APB_SYNC_BRIDGE_TIMEOUT_EN
    logic timeout_q, timeout_d;

    apb_bridge_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_q != ACCESS),
        .enable ((state_q == ACCESS) && !m_PREADY_i),
        .expire (expire)
    );

    assign timeout_o = timeout_q;
`else
    assign expire    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    // A dropped PSEL_i at any point after acceptance discards the response.
    assign abort_now = aborted_q || !PSEL_i;

    // Next-state and next-output logic; every register output is derived here.
    always_comb begin
        state_d   = state_q;
        aborted_d = aborted_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pwrite_d  = pwrite_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        prdata_d  = '0;
        pslverr_d = 1'b0;
`ifdef APB_SYNC_BRIDGE_TIMEOUT_EN
        timeout_d = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (PSEL_i && !pready_q) begin
                    paddr_d   = PADDR_i;
                    pwdata_d  = PWDATA_i;
                    pwrite_d  = PWRITE_i;
                    pstrb_d   = PWRITE_i ? PSTRB_i : '0;
                    pprot_d   = PPROT_i;
                    aborted_d = 1'b0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (!PSEL_i) begin
                    aborted_d = 1'b1;
                end
                state_d = ACCESS;
            end
            ACCESS: begin
                if (!PSEL_i) begin
                    aborted_d = 1'b1;
                end
                if (m_PREADY_i) begin
                    state_d   = abort_now ? IDLE : RESP;
                    prdata_d  = pwrite_q ? '0 : m_PRDATA_i;
                    pslverr_d = m_PSLVERR_i;
                end else if (expire) begin
                    state_d   = abort_now ? IDLE : RESP;
                    pslverr_d = 1'b1;
`ifdef APB_SYNC_BRIDGE_TIMEOUT_EN
                    timeout_d = 1'b1;
`endif
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Response fields are visible only during the single RESP cycle.
        if (state_d != RESP) begin
            prdata_d  = '0;
            pslverr_d = 1'b0;
        end

        m_psel_d    = (state_d == SETUP) || (state_d == ACCESS);
        m_penable_d = (state_d == ACCESS);
        pready_d    = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aborted_q   <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            pready_q    <= 1'b0;
            prdata_q    <= '0;
            pslverr_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            aborted_q   <= aborted_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            m_psel_q    <= m_psel_d;
            m_penable_q <= m_penable_d;
            pready_q    <= pready_d;
            prdata_q    <= prdata_d;
            pslverr_q   <= pslverr_d;
        end
    end

`ifdef APB_SYNC_BRIDGE_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end
`endif

    assign m_PADDR_o   = paddr_q;
    assign m_PWDATA_o  = pwdata_q;
    assign m_PWRITE_o  = pwrite_q;
    assign m_PSTRB_o   = pstrb_q;
    assign m_PPROT_o   = pprot_q;
    assign m_PSEL_o    = m_psel_q;
    assign m_PENABLE_o = m_penable_q;
    assign PREADY_o    = pready_q;
    assign PRDATA_o    = prdata_q;
    assign PSLVERR_o   = pslverr_q;

endmodule
